// File: rtl/camera_pixel_capture_pkg.sv
// Shared definitions for the camera capture path: FSM states, QQVGA geometry
// (also used by the display side) and the luma threshold helper.
package camera_pixel_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_VSYNC = 2'd1,
    S_ACTIVE     = 2'd2,
    S_END        = 2'd3
  } cap_state_t;

  localparam int unsigned QQVGA_H_PIXELS   = 160;
  localparam int unsigned QQVGA_V_LINES    = 120;
  localparam int unsigned QQVGA_ADDR_WIDTH = 15;
  localparam logic [7:0]  DEFAULT_THRESHOLD = 8'd128;

  // Bright luma becomes a lit pixel.
  function automatic logic threshold_pixel(input logic [7:0] luma, input logic [7:0] thr);
    return (luma >= thr);
  endfunction

endpackage

// File: rtl/camera_pixel_capture_edge_detect.sv
// Registered edge detector: level is the input delayed by one cycle, and the
// rise/fall pulses are aligned with that delayed level.
module signal_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  // Delay the level and register the edge pulses against the previous level.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= sig;
      rise  <= sig & ~level;
      fall  <= ~sig & level;
    end
  end

endmodule

// File: rtl/camera_pixel_capture.sv
// Camera capture stage: samples YUV422 bytes, thresholds Y to a 1-bit pixel
// and generates framebuffer write addresses for one frame per v_sync period.
module camera_pixel_capture
  import camera_pixel_capture_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = QQVGA_ADDR_WIDTH,
  parameter int unsigned H_PIXELS   = QQVGA_H_PIXELS,
  parameter int unsigned V_LINES    = QQVGA_V_LINES,
  parameter logic [7:0]  THRESHOLD  = DEFAULT_THRESHOLD
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            data_in,
  input  logic                  h_ref,
  input  logic                  v_sync,
  output logic                  pixel,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  we,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int unsigned X_W = $clog2(H_PIXELS + 1);
  localparam int unsigned Y_W = $clog2(V_LINES + 1);
  localparam logic [X_W-1:0]        X_LIMIT   = X_W'(H_PIXELS);
  localparam logic [Y_W-1:0]        Y_LIMIT   = Y_W'(V_LINES);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_PIXELS);
  localparam longint unsigned       CAPACITY  = 64'd1 << ADDR_WIDTH;
  localparam longint unsigned       FRAME_PIX = longint'(H_PIXELS) * longint'(V_LINES);

  if (FRAME_PIX > CAPACITY) begin : g_geometry_check
    $error("camera_pixel_capture: H_PIXELS*V_LINES exceeds 2**ADDR_WIDTH");
  end

  logic [7:0] data_r;
  logic [7:0] data_d;
  logic       href_r;
  logic       vsync_r;
  logic       href_d;
  logic       href_rise;
  logic       href_fall;
  logic       vsync_d;
  logic       vsync_rise;
  logic       vsync_fall;

  // Single input register on the camera bus; edges come from these copies.
  always_ff @(posedge pclk) begin
    if (reset) begin
      data_r  <= '0;
      href_r  <= 1'b0;
      vsync_r <= 1'b0;
    end else begin
      data_r  <= data_in;
      href_r  <= h_ref;
      vsync_r <= v_sync;
    end
  end

  signal_edge_detect u_href_edge (
    .clk   (pclk),
    .reset (reset),
    .sig   (href_r),
    .level (href_d),
    .rise  (href_rise),
    .fall  (href_fall)
  );

  signal_edge_detect u_vsync_edge (
    .clk   (pclk),
    .reset (reset),
    .sig   (vsync_r),
    .level (vsync_d),
    .rise  (vsync_rise),
    .fall  (vsync_fall)
  );

  // Keep the data byte aligned with the delayed sync levels and edge pulses.
  always_ff @(posedge pclk) begin
    if (reset) begin
      data_d <= '0;
    end else begin
      data_d <= data_r;
    end
  end

  logic phase;
  logic cur_phase;
  logic y_byte;

  // Phase of the byte currently at the processing stage; a line always opens on Y.
  always_comb begin
    cur_phase = href_rise ? 1'b0 : phase;
    y_byte    = href_d && !cur_phase;
  end

  // Byte phase toggles for every byte inside h_ref.
  always_ff @(posedge pclk) begin
    if (reset) begin
      phase <= 1'b0;
    end else if (href_d) begin
      phase <= ~cur_phase;
    end
  end

  cap_state_t state;
  cap_state_t state_next;

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing; enable only matters when leaving IDLE or END.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:       if (enable) state_next = S_WAIT_VSYNC;
      S_WAIT_VSYNC: if (vsync_fall) state_next = S_ACTIVE;
      S_ACTIVE:     if (vsync_rise) state_next = S_END;
      S_END:        state_next = enable ? S_WAIT_VSYNC : S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  logic [X_W-1:0]        x;
  logic [Y_W-1:0]        y;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] line_base;

  // Pixel writes, line/column counting and frame status.
  always_ff @(posedge pclk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      line_base  <= '0;
      pixel      <= 1'b0;
      write_addr <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= (state_next == S_END);

      if (state == S_WAIT_VSYNC && vsync_fall) begin
        x         <= '0;
        y         <= '0;
        addr      <= '0;
        line_base <= '0;
      end

      if (state == S_ACTIVE) begin
        if (y_byte && !vsync_d && (x < X_LIMIT) && (y < Y_LIMIT)) begin
          pixel      <= threshold_pixel(data_d, THRESHOLD);
          write_addr <= addr;
          we         <= 1'b1;
          addr       <= addr + ADDR_WIDTH'(1);
          x          <= x + X_W'(1);
        end
        // Address restarts from the line base so a short line cannot shift later lines.
        if (href_fall && (y < Y_LIMIT)) begin
          y         <= y + Y_W'(1);
          x         <= '0;
          line_base <= line_base + LINE_STEP;
          addr      <= line_base + LINE_STEP;
        end
      end

      if (state == S_END) begin
        frame_err <= frame_err | (y != Y_LIMIT);
      end
    end
  end

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Directed bench for camera_pixel_capture: frames of chosen line lengths are
// driven and every write is compared against addresses/pixels computed here.
`timescale 1ns/1ps
module tb_camera_pixel_capture;

  localparam int unsigned AW = 15;
  localparam int unsigned HP = 160;
  localparam int unsigned VL = 120;

  logic          pclk;
  logic          reset;
  logic          enable;
  logic [7:0]    data_in;
  logic          h_ref;
  logic          v_sync;
  logic          pixel;
  logic [AW-1:0] write_addr;
  logic          we;
  logic          frame_done;
  logic          frame_err;

  camera_pixel_capture #(
    .ADDR_WIDTH (AW),
    .H_PIXELS   (HP),
    .V_LINES    (VL),
    .THRESHOLD  (8'd128)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .h_ref      (h_ref),
    .v_sync     (v_sync),
    .pixel      (pixel),
    .write_addr (write_addr),
    .we         (we),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Write/frame_done monitor, sampled mid-cycle.
  int wr_addr_q[$];
  int wr_pix_q[$];
  int wr_cyc_q[$];
  int fd_count = 0;
  always @(negedge pclk) begin
    if (we === 1'b1) begin
      wr_addr_q.push_back(int'(write_addr));
      wr_pix_q.push_back(int'(pixel));
      wr_cyc_q.push_back(cyc);
    end
    if (frame_done === 1'b1) fd_count++;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int line_len[256];
  int rst_line = -1;
  int last_gap = 4;
  int first_y_edge = 0;
  int post_rst_idx = 0;

  task automatic drive(input logic [7:0] d, input logic hr, input logic vs);
    data_in = d;
    h_ref   = hr;
    v_sync  = vs;
    @(posedge pclk);
    #1;
  endtask

  // Y bytes alternate 0x00/0xFF within each line; chroma bytes are 0x80.
  task automatic send_frame(input int nlines);
    logic [7:0] byt;
    repeat (4) drive(8'h00, 1'b0, 1'b1);
    repeat (4) drive(8'h00, 1'b0, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      for (int b = 0; b < line_len[l]; b++) begin
        byt = (b % 2 == 0) ? (((b / 2) % 2 == 1) ? 8'hFF : 8'h00) : 8'h80;
        if (l == 0 && b == 0) first_y_edge = cyc + 1;
        reset = (l == rst_line) && (b == 10 || b == 11);
        drive(byt, 1'b1, 1'b0);
        if (l == rst_line && b == 10) begin
          check("midframe reset we", 32'(we), 32'd0);
          check("midframe reset write_addr", 32'(write_addr), 32'd0);
          check("midframe reset frame_err", 32'(frame_err), 32'd0);
        end
        if (l == rst_line && b == 11) post_rst_idx = wr_addr_q.size();
      end
      reset = 1'b0;
      if (l != nlines - 1) repeat (4) drive(8'h00, 1'b0, 1'b0);
      else repeat (last_gap) drive(8'h00, 1'b0, 1'b0);
    end
    repeat (6) drive(8'h00, 1'b0, 1'b1);
  endtask

  // Expected writes: line l, Y index i -> addr l*HP+i, pixel i%2, at most HP per line.
  task automatic check_frame(input string name, input int nlines, input int base);
    int k;
    int f0;
    int nw;
    int exp_total;
    k = base;
    f0 = tests_failed;
    exp_total = 0;
    for (int l = 0; l < nlines && l < int'(VL); l++) begin
      nw = line_len[l] / 2;
      if (nw > int'(HP)) nw = int'(HP);
      for (int i = 0; i < nw; i++) begin
        if (tests_failed == f0 && k < wr_addr_q.size()) begin
          check({name, " addr"}, 32'(wr_addr_q[k]), 32'(l * int'(HP) + i));
          check({name, " pixel"}, 32'(wr_pix_q[k]), 32'(i % 2));
        end
        k++;
        exp_total++;
      end
    end
    check({name, " write count"}, 32'(wr_addr_q.size() - base), 32'(exp_total));
  endtask

  int base;
  int fd0;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    data_in = 8'h00;
    h_ref   = 1'b0;
    v_sync  = 1'b0;

    // Reset held with h_ref toggling.
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, (i % 2 == 0), 1'b0);
      check("reset we", 32'(we), 32'd0);
      check("reset write_addr", 32'(write_addr), 32'd0);
      check("reset frame_done", 32'(frame_done), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
    end
    reset  = 1'b0;
    enable = 1'b1;

    // Full frame 120 x 320 bytes; last h_ref fall coincides with v_sync rise.
    for (int l = 0; l < 256; l++) line_len[l] = 320;
    last_gap = 0;
    base = wr_addr_q.size();
    fd0 = fd_count;
    send_frame(120);
    check_frame("full frame", 120, base);
    if (wr_cyc_q.size() > base) check("first write latency", 32'(wr_cyc_q[base] - first_y_edge), 32'd2);
    check("full frame frame_done pulses", 32'(fd_count - fd0), 32'd1);
    check("full frame frame_err", 32'(frame_err), 32'd0);

    // Long line 0 (400 bytes), short line 5 (100 bytes), others 20 bytes.
    for (int l = 0; l < 256; l++) line_len[l] = 20;
    line_len[0] = 400;
    line_len[5] = 100;
    base = wr_addr_q.size();
    fd0 = fd_count;
    send_frame(120);
    check_frame("long/short", 120, base);
    if (wr_addr_q.size() >= base + 251) begin
      check("line1 start addr", 32'(wr_addr_q[base + 160]), 32'd160);
      check("line5 start addr", 32'(wr_addr_q[base + 200]), 32'd800);
      check("line5 end addr", 32'(wr_addr_q[base + 249]), 32'd849);
      check("line6 start addr", 32'(wr_addr_q[base + 250]), 32'd960);
    end else begin
      check("long/short enough writes", 32'(wr_addr_q.size() - base), 32'd251);
    end
    check("long/short frame_done pulses", 32'(fd_count - fd0), 32'd1);
    check("long/short frame_err", 32'(frame_err), 32'd0);

    // Short frame of 100 lines sets the sticky error.
    for (int l = 0; l < 256; l++) line_len[l] = 20;
    last_gap = 4;
    base = wr_addr_q.size();
    fd0 = fd_count;
    send_frame(100);
    check_frame("short frame", 100, base);
    check("short frame frame_done pulses", 32'(fd_count - fd0), 32'd1);
    check("short frame frame_err", 32'(frame_err), 32'd1);

    // Following good frame: error stays set.
    base = wr_addr_q.size();
    fd0 = fd_count;
    send_frame(120);
    check_frame("good after err", 120, base);
    check("good after err frame_done pulses", 32'(fd_count - fd0), 32'd1);
    check("sticky frame_err", 32'(frame_err), 32'd1);

    // Reset at line 60: 600 full-line writes plus Y bytes 0,2,4,6 of line 60 precede it.
    rst_line = 60;
    base = wr_addr_q.size();
    fd0 = fd_count;
    send_frame(120);
    rst_line = -1;
    check("writes before reset", 32'(post_rst_idx - base), 32'd604);
    check("writes after reset", 32'(wr_addr_q.size() - post_rst_idx), 32'd0);
    check("aborted frame_done pulses", 32'(fd_count - fd0), 32'd0);
    check("frame_err after reset", 32'(frame_err), 32'd0);

    // Capture restarts from address 0 on the next frame.
    base = wr_addr_q.size();
    fd0 = fd_count;
    send_frame(120);
    check_frame("restart", 120, base);
    if (wr_addr_q.size() > base) check("restart first addr", 32'(wr_addr_q[base]), 32'd0);
    check("restart frame_done pulses", 32'(fd_count - fd0), 32'd1);
    check("restart frame_err", 32'(frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
